// File: rtl/sipo_receiver.sv
// sipo_receiver: serial-in, parallel-out receiver with a valid/ready output stage.
// Data arrives MSB first. A completed word moves into a separate output
// register, so the next frame can be received while that word waits.
// The optional macro SIPO_RECEIVER_PARITY_EN adds one even-parity bit after
// the data LSB. With the macro undefined (the default), o_ParErr is tied to 0.
module sipo_receiver #(
  parameter int BW_DATA = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rstn,
  input  logic               i_Start,
  input  logic               i_Sin,
  input  logic               i_Sin_vld,
  input  logic               i_Ready,
  output logic [BW_DATA-1:0] o_Qout,
  output logic               o_Valid,
  output logic               o_Busy,
  output logic               o_Overrun,
  output logic               o_ParErr
);

`ifdef SIPO_RECEIVER_PARITY_EN
  localparam int FRAME_LEN = BW_DATA + 1;
  localparam int SW        = BW_DATA;
`else
  localparam int FRAME_LEN = BW_DATA;
  localparam int SW        = BW_DATA - 1;
`endif
  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      shift_q, shift_d;
  logic [SW-1:0]      shiftStep;
  logic [BW_DATA-1:0] qout_q, qout_d;
  logic [BW_DATA-1:0] word;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               shiftEn;
  logic               frameDone;
  logic               loadWord;

`ifdef SIPO_RECEIVER_PARITY_EN
  logic parErr_q, parErr_d;
  logic parBad;

  // The parity bit is the last bit of the frame and is never shifted in.
  // At completion, shift_q already holds the whole data word.
  assign shiftStep = {shift_q[SW-2:0], i_Sin};
  assign shiftEn   = (cnt_q < CW'(BW_DATA));
  assign word      = shift_q;
  assign parBad    = ^{shift_q, i_Sin};
`else
  logic [SW:0] shiftNext;

  // The register keeps only BW_DATA-1 bits. The final bit completes the word
  // combinationally on the edge where it is sampled.
  assign shiftNext = {shift_q, i_Sin};
  assign shiftStep = shiftNext[SW-1:0];
  assign shiftEn   = 1'b1;
  assign word      = shiftNext;
`endif

  // Next-state logic: frame sequencing, bit counting and the shift register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    frameDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (i_Sin_vld) begin
          if (shiftEn) begin
            shift_d = shiftStep;
          end
          if (cnt_q == CW'(FRAME_LEN - 1)) begin
            frameDone = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: load a finished word only when the slot is free or being
  // consumed on this edge; otherwise drop the word and flag the overrun
  always_comb begin
    loadWord  = frameDone && (!valid_q || i_Ready);
    qout_d    = qout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q | (frameDone && valid_q && !i_Ready);
    if (loadWord) begin
      qout_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && i_Ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef SIPO_RECEIVER_PARITY_EN
  // The parity flag belongs to the word in o_Qout, so it loads together with it
  always_comb begin
    parErr_d = parErr_q;
    if (loadWord) begin
      parErr_d = parBad;
    end
  end

  // Parity flag register with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      parErr_q <= 1'b0;
    end else begin
      parErr_q <= parErr_d;
    end
  end

  assign o_ParErr = parErr_q;
`else
  assign o_ParErr = 1'b0;
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      qout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      qout_q    <= qout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_Qout    = qout_q;
  assign o_Valid   = valid_q;
  assign o_Busy    = (state_q == SHIFT);
  assign o_Overrun = overrun_q;

endmodule
